ioctl_loader: RTL and testbench

- Generalised successor to the single-file tape download path: takes the hps_io ioctl byte stream for up to N_IDX OSD file slots and writes each file's payload into system memory through a req/ack write port, stalling hps_io via ioctl_wait.
- Each slot has its own mode: RAW (flat image at a fixed base), KCC (128-byte header carrying load/end/start addresses), or TAP (16-byte tape header, then 129-byte blocks wrapping a KCC stream).
- Reports the parsed addresses and pulses done/autostart so the system can jump to the loaded program.

---
 rtl/ioctl_loader.sv | 154 +++++++++++++++
 tb/tb_ioctl_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_loader.sv
// ioctl_loader: routes hps_io ioctl downloads (RAW/KCC/TAP per slot) into memory over a req/ack write port.
module ioctl_loader #(
  parameter int                   ADDR_W   = 16,
  parameter int                   N_IDX    = 3,
  parameter int                   IDX_BASE = 1,
  parameter logic [2*N_IDX-1:0]   IDX_MODE = {2'd2, 2'd1, 2'd0},
  parameter logic [ADDR_W-1:0]    RAW_BASE = '0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [15:0]       load_addr,
  output logic [15:0]       end_addr,
  output logic [15:0]       start_addr,
  output logic              busy,
  output logic              done,
  output logic              autostart,
  output logic              err
);
  localparam logic [1:0] M_RAW = 2'd0, M_TAP = 2'd2;
  typedef enum logic [2:0] {IDLE, TAPHDR, KCCHDR, DATA, WRITE, FLUSH} state_t;
  state_t state, state_nx;
  logic [1:0] mode, sel_mode;
  logic dl_q, dl_rise, pend, hdr_done, kcc_wr, accept;
  logic [3:0] tap_cnt;
  logic [6:0] hdr_cnt;
  logic [7:0] blk_pos, args;
  logic [15:0] pay_cnt;
  logic [16:0] sum;
  logic [ADDR_W-1:0] target;
  logic unused_addr;
  assign unused_addr = &{1'b0, ioctl_addr[24:ADDR_W]};
  assign dl_rise = ioctl_download && !dl_q;
  // in TAP mode the first byte of every 129-byte block is a block number, not stream data
  assign kcc_wr = ioctl_wr && (mode != M_TAP || blk_pos != 8'd0);
  assign sum = {1'b0, load_addr} + {1'b0, pay_cnt};
  assign target = mode == M_RAW ? RAW_BASE + ioctl_addr[ADDR_W-1:0] : ADDR_W'(sum[15:0]);
  assign accept = state == DATA && ioctl_download && !err &&
                  (mode == M_RAW ? ioctl_wr : kcc_wr && sum < {1'b0, end_addr});
  assign ioctl_wait = mem_req;
  assign busy = state != IDLE && state != FLUSH;
  assign done = state == FLUSH;
  assign autostart = done && mode != M_RAW && args >= 8'd3 && !err && hdr_done;
  always_comb begin
    sel_mode = 2'd3;
    for (int i = 0; i < N_IDX; i++)
      if (ioctl_index == 8'(IDX_BASE + i)) sel_mode = IDX_MODE[2*i +: 2];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (dl_rise && sel_mode != 2'd3)
                 state_nx = sel_mode == M_RAW ? DATA : sel_mode == M_TAP ? TAPHDR : KCCHDR;
      TAPHDR:  state_nx = !ioctl_download ? FLUSH : (ioctl_wr && tap_cnt == 4'd15) ? KCCHDR : TAPHDR;
      KCCHDR:  state_nx = !ioctl_download ? FLUSH : (kcc_wr && hdr_cnt == 7'd127) ? DATA : KCCHDR;
      DATA:    state_nx = !ioctl_download ? FLUSH : accept ? WRITE : DATA;
      WRITE:   state_nx = !mem_ack ? WRITE : (pend || !ioctl_download) ? FLUSH : DATA;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dl_q       <= 1'b0;
      mode       <= M_RAW;
      err        <= 1'b0;
      pend       <= 1'b0;
      hdr_done   <= 1'b0;
      tap_cnt    <= '0;
      hdr_cnt    <= '0;
      blk_pos    <= '0;
      args       <= '0;
      pay_cnt    <= '0;
      load_addr  <= '0;
      end_addr   <= '0;
      start_addr <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_req    <= 1'b0;
    end else begin
      state <= state_nx;
      dl_q  <= ioctl_download;
      case (state)
        IDLE: if (state_nx != IDLE) begin
          mode       <= sel_mode;
          err        <= 1'b0;
          pend       <= 1'b0;
          hdr_done   <= 1'b0;
          tap_cnt    <= '0;
          hdr_cnt    <= '0;
          blk_pos    <= '0;
          args       <= '0;
          pay_cnt    <= '0;
          load_addr  <= '0;
          end_addr   <= '0;
          start_addr <= '0;
        end
        TAPHDR: begin
          if (!ioctl_download) err <= 1'b1;
          else if (ioctl_wr) begin
            tap_cnt <= tap_cnt + 4'd1;
            if (tap_cnt == 4'd0 && ioctl_data != 8'hC3) err <= 1'b1;
          end
        end
        KCCHDR: begin
          if (!ioctl_download) err <= 1'b1;
          else if (ioctl_wr) begin
            if (mode == M_TAP) blk_pos <= blk_pos == 8'd128 ? 8'd0 : blk_pos + 8'd1;
            if (kcc_wr) begin
              hdr_cnt <= hdr_cnt + 7'd1;
              case (hdr_cnt)
                7'd16: args <= ioctl_data;
                7'd17: load_addr[7:0] <= ioctl_data;
                7'd18: load_addr[15:8] <= ioctl_data;
                7'd19: end_addr[7:0] <= ioctl_data;
                7'd20: end_addr[15:8] <= ioctl_data;
                7'd21: start_addr[7:0] <= ioctl_data;
                7'd22: start_addr[15:8] <= ioctl_data;
                7'd127: begin
                  hdr_done <= 1'b1;
                  if (end_addr <= load_addr) err <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        DATA: if (ioctl_download && ioctl_wr) begin
          if (mode == M_TAP) blk_pos <= blk_pos == 8'd128 ? 8'd0 : blk_pos + 8'd1;
          if (mode != M_RAW && kcc_wr) pay_cnt <= pay_cnt + {15'd0, pay_cnt != 16'hFFFF};
          if (accept) begin
            mem_addr <= target;
            mem_data <= ioctl_data;
            mem_req  <= 1'b1;
          end
        end
        WRITE: begin
          pend <= pend || !ioctl_download;
          if (mem_ack) mem_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: directed checks of RAW/KCC/TAP downloads, ack stalls, header errors and async reset.
module tb_ioctl_loader;
  logic clk_sys = 0, reset_n = 0, ioctl_download = 0, ioctl_wr = 0, mem_ack = 0;
  logic [7:0] ioctl_index = 0, ioctl_data = 0, mem_data;
  logic [24:0] ioctl_addr = 0;
  logic [15:0] mem_addr, load_addr, end_addr, start_addr;
  logic ioctl_wait, mem_req, busy, done, autostart, err;
  int n_chk = 0, n_fail = 0;
  int ack_dly = 2, req_age = 0;
  int done_cnt = 0, auto_cnt = 0, both_cnt = 0, wait_cnt = 0, req_cnt = 0, bad_cnt = 0, err_at_done = 0;
  logic [23:0] wq[$];
  logic [23:0] prev = 0;
  logic prev_req = 0;
  int d0, a0, b0, w0, r0, x0, q0;
  always #5 clk_sys = ~clk_sys;
  ioctl_loader #(.RAW_BASE(16'h0200)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_req(mem_req), .mem_ack(mem_ack),
    .load_addr(load_addr), .end_addr(end_addr), .start_addr(start_addr),
    .busy(busy), .done(done), .autostart(autostart), .err(err)
  );
  always @(posedge clk_sys) if (mem_req && mem_ack) wq.push_back({mem_addr, mem_data});
  // memory model: ack arrives ack_dly negedges after req is first seen; ack_dly 0 never acks
  always @(negedge clk_sys) begin
    wait_cnt += int'(ioctl_wait);
    req_cnt  += int'(mem_req);
    done_cnt += int'(done);
    auto_cnt += int'(autostart);
    both_cnt += int'(done && autostart);
    if (done) err_at_done = int'(err);
    if ((mem_req && prev_req && {mem_addr, mem_data} != prev) || (done && mem_req)) bad_cnt++;
    prev = {mem_addr, mem_data};
    prev_req = mem_req;
    if (mem_req && !mem_ack) begin
      if (ack_dly != 0 && req_age == ack_dly - 1) mem_ack = 1;
      else req_age++;
    end else begin
      mem_ack = 0;
      req_age = 0;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic snap();
    d0 = done_cnt; a0 = auto_cnt; b0 = both_cnt; w0 = wait_cnt; r0 = req_cnt; x0 = bad_cnt; q0 = wq.size();
  endtask
  task automatic byte_out(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1;
    @(negedge clk_sys);
    ioctl_wr = 0;
    while (ioctl_wait && n < 100) begin @(negedge clk_sys); n++; end
    if (n >= 100) check("wait_bound", n, 0);
  endtask
  task automatic start(input logic [7:0] idx);
    snap();
    ioctl_index = idx; ioctl_download = 1;
    @(negedge clk_sys);
  endtask
  task automatic finish_dl();
    ioctl_download = 0;
    repeat (12) @(negedge clk_sys);
  endtask
  function automatic logic [7:0] hb(input int i, input logic [7:0] a, input logic [15:0] ld, en, st);
    case (i)
      16: return a;
      17: return ld[7:0];
      18: return ld[15:8];
      19: return en[7:0];
      20: return en[15:8];
      21: return st[7:0];
      22: return st[15:8];
      default: return 8'h00;
    endcase
  endfunction
  task automatic send_hdr(input logic [7:0] a, input logic [15:0] ld, en, st);
    for (int i = 0; i < 128; i++) byte_out(0, hb(i, a, ld, en, st));
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk_sys);
    check("rst_req", mem_req, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    reset_n = 1;
    @(negedge clk_sys);
    // RAW slot 0
    start(8'd1);
    check("raw_busy", busy, 1);
    byte_out(0, 8'hAA); byte_out(1, 8'hBB); byte_out(2, 8'hCC); byte_out(3, 8'hDD);
    finish_dl();
    check("raw_nw", wq.size() - q0, 4);
    check("raw_w0", wq[q0], 24'h0200AA);
    check("raw_w1", wq[q0+1], 24'h0201BB);
    check("raw_w2", wq[q0+2], 24'h0202CC);
    check("raw_w3", wq[q0+3], 24'h0203DD);
    check("raw_wait", wait_cnt - w0, 8);
    check("raw_done", done_cnt - d0, 1);
    check("raw_auto", auto_cnt - a0, 0);
    check("raw_idle", busy, 0);
    // KCC slot 1: payload past end_addr dropped
    start(8'd2);
    send_hdr(8'd3, 16'h0300, 16'h0304, 16'h0310);
    for (int i = 0; i < 6; i++) byte_out(0, 8'h11 + 8'(i));
    finish_dl();
    check("kcc_nw", wq.size() - q0, 4);
    check("kcc_w0", wq[q0], 24'h030011);
    check("kcc_w3", wq[q0+3], 24'h030314);
    check("kcc_wait", wait_cnt - w0, 8);
    check("kcc_done", done_cnt - d0, 1);
    check("kcc_both", both_cnt - b0, 1);
    check("kcc_auto", auto_cnt - a0, 1);
    check("kcc_start", start_addr, 16'h0310);
    check("kcc_load", load_addr, 16'h0300);
    check("kcc_end", end_addr, 16'h0304);
    check("kcc_err", err_at_done, 0);
    // TAP slot 2
    start(8'd3);
    byte_out(0, 8'hC3);
    for (int i = 1; i < 16; i++) byte_out(0, 8'h00);
    byte_out(0, 8'h01);
    send_hdr(8'd3, 16'h1000, 16'h1010, 16'h1000);
    byte_out(0, 8'hFF);
    byte_out(0, 8'hA0); byte_out(0, 8'hA1); byte_out(0, 8'hA2);
    finish_dl();
    check("tap_nw", wq.size() - q0, 3);
    check("tap_w0", wq[q0], 24'h1000A0);
    check("tap_w2", wq[q0+2], 24'h1002A2);
    check("tap_auto", both_cnt - b0, 1);
    check("tap_err", err_at_done, 0);
    // TAP with bad magic
    start(8'd3);
    for (int i = 0; i < 16; i++) byte_out(0, 8'h00);
    check("tapbad_err", err, 1);
    check("tapbad_busy", busy, 1);
    finish_dl();
    check("tapbad_done", done_cnt - d0, 1);
    check("tapbad_auto", auto_cnt - a0, 0);
    check("tapbad_errd", err_at_done, 1);
    // slow ack with download dropped during WRITE
    ack_dly = 7;
    start(8'd1);
    check("slow_errclr", err, 0);
    ioctl_addr = 5; ioctl_data = 8'h5A; ioctl_wr = 1;
    @(negedge clk_sys);
    ioctl_wr = 0;
    check("slow_req", mem_req, 1);
    finish_dl();
    check("slow_reqcyc", req_cnt - r0, 7);
    check("slow_stable", bad_cnt - x0, 0);
    check("slow_nw", wq.size() - q0, 1);
    check("slow_w0", wq[q0], 24'h02055A);
    check("slow_done", done_cnt - d0, 1);
    ack_dly = 2;
    // KCC with end == load
    start(8'd2);
    send_hdr(8'd3, 16'h0400, 16'h0400, 16'h0400);
    byte_out(0, 8'h55); byte_out(0, 8'h66);
    check("eq_wait", wait_cnt - w0, 0);
    finish_dl();
    check("eq_nw", wq.size() - q0, 0);
    check("eq_done", done_cnt - d0, 1);
    check("eq_auto", auto_cnt - a0, 0);
    check("eq_err", err_at_done, 1);
    // index outside slot range
    start(8'd9);
    byte_out(0, 8'h99);
    check("oor_busy", busy, 0);
    check("oor_wait", wait_cnt - w0, 0);
    finish_dl();
    check("oor_done", done_cnt - d0, 0);
    check("oor_nw", wq.size() - q0, 0);
    // async reset mid-WRITE
    ack_dly = 0;
    start(8'd1);
    ioctl_addr = 3; ioctl_data = 8'h33; ioctl_wr = 1;
    @(negedge clk_sys);
    ioctl_wr = 0;
    check("rw_req", mem_req, 1);
    #2 reset_n = 0;
    #1;
    check("rw_req0", mem_req, 0);
    check("rw_wait0", ioctl_wait, 0);
    check("rw_busy0", busy, 0);
    ioctl_download = 0;
    @(negedge clk_sys);
    reset_n = 1;
    ack_dly = 2;
    repeat (3) @(negedge clk_sys);
    check("rw_nodone", done_cnt - d0, 0);
    start(8'd1);
    byte_out(7, 8'h77);
    finish_dl();
    check("rw2_nw", wq.size() - q0, 1);
    check("rw2_w0", wq[q0], 24'h020777);
    check("rw2_done", done_cnt - d0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
